// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: binary32 field layout, common
// constants and the complex-multiplier sequencer states.
package fft_pkg;

    localparam int FP_W        = 32;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_EXP_BIAS = 127;

    localparam logic [FP_W-1:0]     FP_ONE     = 32'h3F80_0000;
    localparam logic [FP_W-1:0]     FP_ZERO    = 32'h0000_0000;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        S0,
        S1,
        DONE
    } cmul_state_t;

endpackage

// File: rtl/fp_addsub.sv
// Combinational binary32 add/subtract (SUB flips B's sign): denormals as
// zero, guard/sticky alignment, truncation, exact cancellation gives +0.
module fp_addsub
    import fft_pkg::*;
(
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    input  logic            SUB,
    output logic [FP_W-1:0] S,
    output logic            EX
);

    logic [FP_W-1:0]   b_eff;
    logic              a_zero, b_zero, a_spec, b_spec;
    logic [FP_W-1:0]   big, sml;
    logic [7:0]        exp_diff;
    logic [26:0]       big_m, sml_m, sml_al;
    logic [27:0]       sum;
    logic [26:0]       dif, norm;
    logic [4:0]        lz;
    logic              lz_found;
    logic signed [9:0] exp_r;
    logic              is_zero;
    logic [FP_W-1:0]   ar_s;
    logic              ar_ex;
    logic              unused_norm;

    assign b_eff  = {B[31] ^ SUB, B[30:0]};
    assign a_zero = (A[30:23] == 8'h00);
    assign b_zero = (B[30:23] == 8'h00);
    assign a_spec = (A[30:23] == FP_EXP_MAX);
    assign b_spec = (B[30:23] == FP_EXP_MAX);

    // Order by magnitude so the mantissa difference is never negative.
    assign big      = (A[30:0] >= b_eff[30:0]) ? A : b_eff;
    assign sml      = (A[30:0] >= b_eff[30:0]) ? b_eff : A;
    assign exp_diff = big[30:23] - sml[30:23];
    assign big_m    = {1'b1, big[22:0], 3'b000};
    assign sml_m    = {1'b1, sml[22:0], 3'b000};

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sml_al = 27'd1;
        if (exp_diff < 8'd27) begin
            sml_al = (sml_m >> exp_diff)
                   | {26'b0, |(sml_m & ((27'd1 << exp_diff) - 27'd1))};
        end
    end

    always_comb begin
        sum      = {1'b0, big_m} + {1'b0, sml_al};
        dif      = big_m - sml_al;
        norm     = '0;
        lz       = '0;
        lz_found = 1'b0;
        exp_r    = $signed({2'b00, big[30:23]});
        is_zero  = 1'b0;
        if (big[31] == sml[31]) begin
            if (sum[27]) begin
                norm  = {sum[27:2], sum[1] | sum[0]};
                exp_r = exp_r + 10'sd1;
            end else begin
                norm = sum[26:0];
            end
        end else if (dif == 27'd0) begin
            is_zero = 1'b1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!lz_found && dif[i]) begin
                    lz       = 5'(26 - i);
                    lz_found = 1'b1;
                end
            end
            norm  = dif << lz;
            exp_r = exp_r - $signed({5'b0, lz});
        end
    end

    assign unused_norm = ^{norm[26], norm[2:0]};

    always_comb begin
        ar_s  = {big[31], exp_r[7:0], norm[25:3]};
        ar_ex = 1'b0;
        if (is_zero) begin
            ar_s = FP_ZERO;
        end else if (exp_r >= 10'sd255) begin
            ar_s  = {big[31], FP_EXP_MAX, 23'b0};
            ar_ex = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            ar_s  = {big[31], 31'b0};
            ar_ex = 1'b1;
        end
    end

    always_comb begin
        S  = ar_s;
        EX = ar_ex;
        if (a_spec) begin
            S  = A;
            EX = 1'b1;
        end else if (b_spec) begin
            S  = b_eff;
            EX = 1'b1;
        end else if (a_zero && b_zero) begin
            S  = {A[31] & b_eff[31], 31'b0};
            EX = 1'b0;
        end else if (a_zero) begin
            S  = b_eff;
            EX = 1'b0;
        end else if (b_zero) begin
            S  = A;
            EX = 1'b0;
        end
    end

endmodule

// File: rtl/mul.sv
// Combinational binary32 multiplier: denormals read as zero, truncating,
// EX on inf/NaN operands and on exponent overflow/underflow.
module mul
    import fft_pkg::*;
(
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    output logic [FP_W-1:0] P,
    output logic            EX
);

    logic                sign;
    logic [47:0]         prod;
    logic signed [9:0]   exp_sum;
    logic signed [9:0]   exp_n;
    logic [FP_MAN_W-1:0] man;
    logic                unused_prod_lsbs;

    assign sign             = A[31] ^ B[31];
    assign prod             = {1'b1, A[22:0]} * {1'b1, B[22:0]};
    assign exp_sum          = $signed({2'b00, A[30:23]}) + $signed({2'b00, B[30:23]})
                              - 10'sd127;
    assign exp_n            = exp_sum + $signed({9'b0, prod[47]});
    assign man              = prod[47] ? prod[46:24] : prod[45:23];
    assign unused_prod_lsbs = ^prod[22:0];

    always_comb begin
        P  = FP_ZERO;
        EX = 1'b0;
        if (A[30:23] == FP_EXP_MAX) begin
            P  = {sign, A[30:0]};
            EX = 1'b1;
        end else if (B[30:23] == FP_EXP_MAX) begin
            P  = {sign, B[30:0]};
            EX = 1'b1;
        end else if (A[30:23] == 8'h00 || B[30:23] == 8'h00) begin
            P = {sign, 31'b0};
        end else if (exp_n >= 10'sd255) begin
            P  = {sign, FP_EXP_MAX, 23'b0};
            EX = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            P  = {sign, 31'b0};
            EX = 1'b1;
        end else begin
            P = {sign, exp_n[7:0], man};
        end
    end

endmodule

// File: rtl/fft_cmul_seq.sv
// Sequential binary32 complex multiply y = a*w over one shared mul and one
// shared fp_addsub. Optional unity-twiddle shortcut: FFT_CMUL_UNITY_BYPASS_EN.
module fft_cmul_seq
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_re,
    input  logic [31:0] a_im,
    input  logic [31:0] w_re,
    input  logic [31:0] w_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_re,
    output logic [31:0] y_im,
    output logic        ex
);

    cmul_state_t state_q, state_d;
    logic [31:0] ar_q, ar_d, ai_q, ai_d, wr_q, wr_d, wi_q, wi_d;
    logic [31:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [31:0] y_re_q, y_re_d, y_im_q, y_im_d;
    logic        ex_q, ex_d;

    logic [31:0] mul_a, mul_b, mul_p;
    logic        mul_ex;
    logic [31:0] add_a, add_b, add_s;
    logic        add_sub, add_ex;

    mul u_mul (
        .A  (mul_a),
        .B  (mul_b),
        .P  (mul_p),
        .EX (mul_ex)
    );

    fp_addsub u_addsub (
        .A   (add_a),
        .B   (add_b),
        .SUB (add_sub),
        .S   (add_s),
        .EX  (add_ex)
    );

    always_comb begin
        mul_a = ar_q;
        mul_b = wr_q;
        case (state_q)
            M1:      begin mul_a = ai_q; mul_b = wi_q; end
            M2:      begin mul_a = ar_q; mul_b = wi_q; end
            M3:      begin mul_a = ai_q; mul_b = wr_q; end
            default: ;
        endcase
    end

    // S0 forms p0 - p1 (real part), S1 forms p2 + p3 (imaginary part).
    always_comb begin
        add_a   = (state_q == S1) ? p2_q : p0_q;
        add_b   = (state_q == S1) ? p3_q : p1_q;
        add_sub = (state_q != S1);
    end

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        wr_d    = wr_q;
        wi_d    = wi_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        y_re_d  = y_re_q;
        y_im_d  = y_im_q;
        ex_d    = ex_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ar_d    = a_re;
                    ai_d    = a_im;
                    wr_d    = w_re;
                    wi_d    = w_im;
                    ex_d    = 1'b0;
                    state_d = M0;
`ifdef FFT_CMUL_UNITY_BYPASS_EN
                    if (w_re == FP_ONE && w_im == FP_ZERO) begin
                        y_re_d  = a_re;
                        y_im_d  = a_im;
                        state_d = DONE;
                    end
`endif
                end
            end
            M0: begin p0_d = mul_p; ex_d = ex_q | mul_ex; state_d = M1; end
            M1: begin p1_d = mul_p; ex_d = ex_q | mul_ex; state_d = M2; end
            M2: begin p2_d = mul_p; ex_d = ex_q | mul_ex; state_d = M3; end
            M3: begin p3_d = mul_p; ex_d = ex_q | mul_ex; state_d = S0; end
            S0: begin y_re_d = add_s; ex_d = ex_q | add_ex; state_d = S1; end
            S1: begin y_im_d = add_s; ex_d = ex_q | add_ex; state_d = DONE; end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values. The partial-product registers are reset
    // too, because they are architecturally visible through the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ar_q    <= '0;
            ai_q    <= '0;
            wr_q    <= '0;
            wi_q    <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            y_re_q  <= '0;
            y_im_q  <= '0;
            ex_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            wr_q    <= wr_d;
            wi_q    <= wi_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            y_re_q  <= y_re_d;
            y_im_q  <= y_im_d;
            ex_q    <= ex_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign ex        = ex_q;

endmodule

// File: tb/tb_fft_cmul_seq.sv
// Directed bench for fft_cmul_seq with hand-computed binary32 results; the
// unity-twiddle latency follows FFT_CMUL_UNITY_BYPASS_EN.
module tb_fft_cmul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y_re, y_im;
    logic        ex;

    int n_cmp = 0;
    int n_err = 0;

    // Latencies count the accepting edge itself.
    localparam int FULL_LAT = 7;
`ifdef FFT_CMUL_UNITY_BYPASS_EN
    localparam int UNITY_LAT = 1;
`else
    localparam int UNITY_LAT = 7;
`endif

    fft_cmul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .ex        (ex)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input logic [31:0] ar, input logic [31:0] ai,
                             input logic [31:0] wr, input logic [31:0] wi);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("accept_in_ready", 32'(in_ready), 32'd1);
        a_re     = ar;
        a_im     = ai;
        w_re     = wr;
        w_im     = wi;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Called right after the accepting edge; counts edges until out_valid.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [31:0] er,
                                input logic [31:0] ei, input logic ee);
        check({tag, "_y_re"}, y_re, er);
        check({tag, "_y_im"}, y_im, ei);
        check({tag, "_ex"}, 32'(ex), 32'(ee));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_released_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_released_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ar, input logic [31:0] ai,
                          input logic [31:0] wr, input logic [31:0] wi, input int exp_lat,
                          input logic [31:0] er, input logic [31:0] ei, input logic ee);
        accept_op(ar, ai, wr, wi);
        wait_valid(tag, exp_lat);
        check_result(tag, er, ei, ee);
        release_out(tag);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y_re", y_re, 32'h0);
        check("reset_y_im", y_im, 32'h0);
        check("reset_ex", 32'(ex), 32'd0);

        // (3+4j)(0.5+0.5j) = -0.5 + 3.5j
        run_op("basic", 32'h40400000, 32'h40800000, 32'h3F000000, 32'h3F000000,
               FULL_LAT, 32'hBF000000, 32'h40600000, 1'b0);

        // (2+3j)(-j) = 3 - 2j, then hold DONE with a new operand offered.
        accept_op(32'h40000000, 32'h40400000, 32'h00000000, 32'hBF800000);
        wait_valid("bp", FULL_LAT);
        a_re     = 32'h3F800000;
        a_im     = 32'h3F800000;
        w_re     = 32'h3F800000;
        w_im     = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check_result("bp_hold", 32'h40400000, 32'hC0000000, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        // (1+j)(1+j) = 0 + 2j, with exact cancellation in the real part.
        wait_valid("cancel", FULL_LAT);
        check_result("cancel", 32'h00000000, 32'h40000000, 1'b0);
        release_out("cancel");

        // 2^127 * 2 overflows in the first product.
        run_op("ovf", 32'h7F000000, 32'h00000000, 32'h40000000, 32'h00000000,
               FULL_LAT, 32'h7F800000, 32'h00000000, 1'b1);

        // Reset while in M2: the operation is discarded.
        accept_op(32'h40400000, 32'h40800000, 32'h3F000000, 32'h3F000000);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_ex", 32'(ex), 32'd0);
        check("rst_mid_y_re", y_re, 32'h0);
        check("rst_mid_y_im", y_im, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_mid_no_output", 32'(out_valid), 32'd0);
        end

        // Unity twiddle: result equals a bit-exact.
        run_op("unity", 32'h4234851F, 32'hC1663D71, 32'h3F800000, 32'h00000000,
               UNITY_LAT, 32'h4234851F, 32'hC1663D71, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
